wshb_arbiter2: RTL and testbench
================================

Name: wshb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter sharing the SDRAM Wishbone port.
- Master 0 is the VGA frame-buffer reader: continuous reads, cyc held high permanently, cti=3'b010.
- Master 1 is a frame-buffer writer, e.g. a test-pattern or image loader.
- Round-robin ownership with a per-grant ack quota, so a master holding cyc forever cannot starve the other. Sits between both masters and the SDRAM controller in the wshb_if clock domain.

Parameters:
ADR_W, 32, address width
DATA_W, 32, data width; SEL width is DATA_W/8
QUOTA, 64, max acks per grant while the other master waits; 0 = unlimited

Ports:
clk  in  1  Wishbone clock
rst_n  in  1  asynchronous active-low reset
m0_cyc, m1_cyc  in  1  master cycle request
m0_stb, m1_stb  in  1  master strobe
m0_we, m1_we  in  1  master write enable
m0_adr, m1_adr  in  ADR_W  master byte address
m0_sel, m1_sel  in  DATA_W/8  byte selects
m0_cti, m1_cti  in  3  cycle type
m0_bte, m1_bte  in  2  burst type
m0_dat_ms, m1_dat_ms  in  DATA_W  write data
m0_dat_sm, m1_dat_sm  out  DATA_W  read data; both are s_dat_sm
m0_ack, m1_ack  out  1  ack, gated to owner only
s_cyc, s_stb, s_we  out  1  slave controls
s_adr  out  ADR_W  slave address
s_sel  out  DATA_W/8  slave byte selects
s_cti, s_bte  out  3/2  slave cycle/burst type
s_dat_ms  out  DATA_W  slave write data
s_dat_sm  in  DATA_W  slave read data
s_ack  in  1  slave ack
gnt  out  2  one-hot owner: 01=m0, 10=m1, 00=none

Behaviour:
- FSM states: IDLE, OWN0, OWN1. The state register, last-served bit `last` and ack counter `qcnt` are all registered.
- Reset (async, rst_n=0): state=IDLE, last=1 (m0 wins the first tie), qcnt=0. Reset mid-transfer aborts it immediately.
- Outputs in IDLE: all s_* are 0, both mN_ack are 0, gnt=00.
- Outputs in OWNn: every s_* output is a combinational copy of the mN_* input. mN_ack=s_ack; the other master's ack is 0. gnt is one-hot n.
- IDLE arbitration:
  - Only one mN_cyc high -> OWNn.
  - Both high -> OWN of the master != last.
  - Neither -> stay in IDLE.
  - Latency is 1 cycle: s_cyc rises the cycle after entry to OWNn.
- On entering OWNn: last<=n, qcnt<=0.
- In OWNn, each s_ack increments qcnt, saturating at QUOTA.
- Leave OWNn -> IDLE (always via IDLE, so s_cyc is low for at least 1 cycle between owners) when any of:
  - (a) mN_cyc=0;
  - (b) s_ack & mN_cti==3'b111 & other cyc=1;
  - (c) QUOTA!=0 & s_ack & qcnt==QUOTA-1 & other cyc=1.
- Preemption under (b)/(c): the preempted master keeps cyc/stb/adr and sees no ack until re-granted. It is then granted from IDLE by round-robin.
- If the other master is idle, the owner keeps the grant indefinitely; the quota is not enforced.
- Handoff gap: the last owner ack is at cycle t, s_cyc=0 at t+1, the new owner's s_cyc=1 at t+2.
- An s_ack arriving in IDLE is dropped; it is not forwarded to either master.

Optional Feature:
- WSHB_ARB_STATS_EN defined: adds output ports wait0, wait1 (16 bits each).
  - waitN increments every cycle with mN_cyc=1 and gnt[N]=0.
  - Saturates at 16'hFFFF; reset to 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package wshb_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, OWN0, OWN1};
  - localparams CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
- Single module; no sub-module. The per-master request/ack mux is a generate loop over 2.

Test Plan:
- Reset, then m0_cyc=1 only -> gnt=01 one cycle later; s_adr tracks m0_adr; m1_ack stays 0.
- Simultaneous first request from both -> m0 granted first. m0 drops cyc after 3 acks -> 1 cycle s_cyc=0, then gnt=10.
- QUOTA=4, m0 holds cyc forever with cti=010, m1 requests -> exactly 4 m0 acks, gap cycle, m1 served. m1 drops cyc -> m0 resumes with its held address.
- m1 issues cti=111 on an ack while m0 waits -> release after that ack; m0 owns 2 cycles later.
- Reset asserted mid-grant -> outputs zero immediately. Release reset with both requesting -> m0 granted.
- WSHB_ARB_STATS_EN: m1 waits 10 cycles -> wait1=10, wait0 unchanged.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wshb_arb_pkg;

    // Arbiter ownership state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Wishbone registered-feedback cycle type codes.
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wshb_arbiter2_if.sv
// One Wishbone B4 point-to-point link (master side drives requests, slave side answers).
interface wshb_arbiter2_if
    import wshb_arb_pkg::*;
#(
    parameter int unsigned ADR_W  = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [SEL_W-1:0]  sel;
    logic [2:0]        cti;
    logic [1:0]        bte;
    logic [DATA_W-1:0] dat_ms;
    logic [DATA_W-1:0] dat_sm;
    logic              ack;

    modport master (
        output cyc, stb, we, adr, sel, cti, bte, dat_ms,
        input  dat_sm, ack
    );

    modport slave (
        input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
        output dat_sm, ack
    );

endinterface

// File: rtl/wshb_arbiter2.sv
// Two-master / one-slave Wishbone arbiter for the shared SDRAM port.
// Round-robin ownership with a per-grant ack quota; handoffs always pass
// through IDLE so the slave sees s_cyc low for at least one cycle.
// Optional build macro WSHB_ARB_STATS_EN adds saturating wait0/wait1 counters.
module wshb_arbiter2
    import wshb_arb_pkg::*;
#(
    parameter int unsigned ADR_W  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned QUOTA  = 64
)(
    input  logic             clk,
    input  logic             rst_n,
    wshb_arbiter2_if.slave   m0,
    wshb_arbiter2_if.slave   m1,
    wshb_arbiter2_if.master  s,
    output logic [1:0]       gnt
`ifdef WSHB_ARB_STATS_EN
    ,
    output logic [15:0]      wait0,
    output logic [15:0]      wait1
`endif
);

    localparam int unsigned SEL_W  = DATA_W / 8;
    localparam int unsigned QCNT_W = (QUOTA > 1) ? $clog2(QUOTA + 1) : 1;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last;
    logic [QCNT_W-1:0] qcnt;
    logic [1:0]        gnt_c;
    logic [1:0]        rel_c;
    logic [1:0]        ack_c;
    logic              quota_hit_c;

    // Requests gathered into per-master arrays for the generate loop.
    logic [1:0]        req_cyc;
    logic [1:0]        req_stb;
    logic [1:0]        req_we;
    logic [ADR_W-1:0]  req_adr [2];
    logic [SEL_W-1:0]  req_sel [2];
    logic [2:0]        req_cti [2];
    logic [1:0]        req_bte [2];
    logic [DATA_W-1:0] req_dat [2];

    assign req_cyc    = {m1.cyc, m0.cyc};
    assign req_stb    = {m1.stb, m0.stb};
    assign req_we     = {m1.we,  m0.we};
    assign req_adr[0] = m0.adr;
    assign req_adr[1] = m1.adr;
    assign req_sel[0] = m0.sel;
    assign req_sel[1] = m1.sel;
    assign req_cti[0] = m0.cti;
    assign req_cti[1] = m1.cti;
    assign req_bte[0] = m0.bte;
    assign req_bte[1] = m1.bte;
    assign req_dat[0] = m0.dat_ms;
    assign req_dat[1] = m1.dat_ms;

    // Quota reached on this ack (QUOTA of zero disables preemption by count).
    assign quota_hit_c = (QUOTA != 0) && s.ack && (qcnt == QCNT_W'(QUOTA - 1));

    logic [2:0]        ctl_term [2];
    logic [ADR_W-1:0]  adr_term [2];
    logic [SEL_W-1:0]  sel_term [2];
    logic [2:0]        cti_term [2];
    logic [1:0]        bte_term [2];
    logic [DATA_W-1:0] dat_term [2];

    // Per-master AND-OR request mux, ack gating and release conditions.
    for (genvar g = 0; g < 2; g++) begin : g_master
        localparam int unsigned OTH = 1 - g;

        assign ctl_term[g] = {req_cyc[g], req_stb[g], req_we[g]} & {3{gnt_c[g]}};
        assign adr_term[g] = req_adr[g] & {ADR_W{gnt_c[g]}};
        assign sel_term[g] = req_sel[g] & {SEL_W{gnt_c[g]}};
        assign cti_term[g] = req_cti[g] & {3{gnt_c[g]}};
        assign bte_term[g] = req_bte[g] & {2{gnt_c[g]}};
        assign dat_term[g] = req_dat[g] & {DATA_W{gnt_c[g]}};

        assign ack_c[g] = gnt_c[g] & s.ack;

        // Owner drops cyc, ends a burst while the other waits, or uses up its quota.
        assign rel_c[g] = !req_cyc[g]
                        | (s.ack & (req_cti[g] == CTI_EOB) & req_cyc[OTH])
                        | (quota_hit_c & req_cyc[OTH]);
    end

    assign {s.cyc, s.stb, s.we} = ctl_term[0] | ctl_term[1];
    assign s.adr    = adr_term[0] | adr_term[1];
    assign s.sel    = sel_term[0] | sel_term[1];
    assign s.cti    = cti_term[0] | cti_term[1];
    assign s.bte    = bte_term[0] | bte_term[1];
    assign s.dat_ms = dat_term[0] | dat_term[1];

    assign m0.ack    = ack_c[0];
    assign m1.ack    = ack_c[1];
    assign m0.dat_sm = s.dat_sm;
    assign m1.dat_sm = s.dat_sm;
    assign gnt       = gnt_c;

    // Ownership state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decode; ties in IDLE go to the master not served last.
    always_comb begin
        state_nxt = state;
        gnt_c     = 2'b00;
        case (state)
            IDLE: begin
                if (req_cyc[0] && req_cyc[1]) begin
                    state_nxt = last ? OWN0 : OWN1;
                end else if (req_cyc[0]) begin
                    state_nxt = OWN0;
                end else if (req_cyc[1]) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                gnt_c = 2'b01;
                if (rel_c[0]) begin
                    state_nxt = IDLE;
                end
            end
            OWN1: begin
                gnt_c = 2'b10;
                if (rel_c[1]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Last-served bit and per-grant saturating ack counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
            qcnt <= '0;
        end else if (state == IDLE && state_nxt == OWN0) begin
            last <= 1'b0;
            qcnt <= '0;
        end else if (state == IDLE && state_nxt == OWN1) begin
            last <= 1'b1;
            qcnt <= '0;
        end else if (state != IDLE && s.ack && qcnt != QCNT_W'(QUOTA)) begin
            qcnt <= qcnt + QCNT_W'(1);
        end
    end

`ifdef WSHB_ARB_STATS_EN
    // Cycles each master spends requesting without the grant, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait0 <= '0;
            wait1 <= '0;
        end else begin
            if (req_cyc[0] && !gnt_c[0] && wait0 != 16'hFFFF) begin
                wait0 <= wait0 + 16'd1;
            end
            if (req_cyc[1] && !gnt_c[1] && wait1 != 16'hFFFF) begin
                wait1 <= wait1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wshb_arbiter2.sv
// Self-checking bench for wshb_arbiter2: directed scenarios plus a random run,
// every cycle compared against an ownership model built from the arbitration rules.
module tb_wshb_arbiter2;
    import wshb_arb_pkg::*;

    localparam int unsigned Q = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] gnt;
`ifdef WSHB_ARB_STATS_EN
    logic [15:0] wait0;
    logic [15:0] wait1;
`endif

    wshb_arbiter2_if #(.ADR_W(32), .DATA_W(32)) m0_bus ();
    wshb_arbiter2_if #(.ADR_W(32), .DATA_W(32)) m1_bus ();
    wshb_arbiter2_if #(.ADR_W(32), .DATA_W(32)) s_bus ();

    wshb_arbiter2 #(.ADR_W(32), .DATA_W(32), .QUOTA(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .gnt   (gnt)
`ifdef WSHB_ARB_STATS_EN
        ,
        .wait0 (wait0),
        .wait1 (wait1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current owner (-1 none), last served, acks this grant, wait counts.
    int m_owner;
    int m_last;
    int m_q;
    int m_wait [2];

    logic [1:0]  obs_gnt;
    logic [1:0]  obs_ack;
    logic [31:0] obs_sadr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [75:0] mfields(input int n);
        if (n == 0)
            return {m0_bus.cyc, m0_bus.stb, m0_bus.we, m0_bus.adr, m0_bus.sel,
                    m0_bus.cti, m0_bus.bte, m0_bus.dat_ms};
        return {m1_bus.cyc, m1_bus.stb, m1_bus.we, m1_bus.adr, m1_bus.sel,
                m1_bus.cti, m1_bus.bte, m1_bus.dat_ms};
    endfunction

    function automatic logic [75:0] sfields();
        return {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.sel,
                s_bus.cti, s_bus.bte, s_bus.dat_ms};
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_last    = 1;
        m_q       = 0;
        m_wait[0] = 0;
        m_wait[1] = 0;
    endtask

    task automatic drive(input int n, input logic cyc, input logic [2:0] cti, input logic [31:0] adr);
        if (n == 0) begin
            m0_bus.cyc = cyc; m0_bus.stb = cyc; m0_bus.we = 1'b0; m0_bus.adr = adr;
            m0_bus.sel = 4'hF; m0_bus.cti = cti; m0_bus.bte = 2'b00; m0_bus.dat_ms = $urandom();
        end else begin
            m1_bus.cyc = cyc; m1_bus.stb = cyc; m1_bus.we = 1'b1; m1_bus.adr = adr;
            m1_bus.sel = 4'hF; m1_bus.cti = cti; m1_bus.bte = 2'b00; m1_bus.dat_ms = $urandom();
        end
    endtask

    // One clock: compare at negedge, advance the model, return at posedge+1.
    task automatic step();
        logic [75:0] exp_bus;
        logic [1:0]  exp_ack;
        logic [1:0]  exp_gnt;
        logic        c [2];
        logic [2:0]  cti_o;
        int          o;
        int          oth;
        bit          leave;
        @(negedge clk);
        o = m_owner;
        c[0] = m0_bus.cyc;
        c[1] = m1_bus.cyc;
        exp_bus = (o < 0) ? '0 : mfields(o);
        exp_gnt = (o < 0) ? 2'b00 : (2'b01 << o);
        exp_ack = s_bus.ack ? exp_gnt : 2'b00;
        obs_gnt  = gnt;
        obs_ack  = {m1_bus.ack, m0_bus.ack};
        obs_sadr = s_bus.adr;
        check("s_bus", sfields(), exp_bus);
        check("gnt", gnt, exp_gnt);
        check("ack", {m1_bus.ack, m0_bus.ack}, exp_ack);
        check("rdat", {m1_bus.dat_sm, m0_bus.dat_sm}, {2{s_bus.dat_sm}});
`ifdef WSHB_ARB_STATS_EN
        check("wait0", wait0, m_wait[0]);
        check("wait1", wait1, m_wait[1]);
        for (int n = 0; n < 2; n++)
            if (c[n] && !exp_gnt[n] && m_wait[n] < 65535) m_wait[n]++;
`endif
        if (o < 0) begin
            if (c[0] && c[1]) m_owner = (m_last == 1) ? 0 : 1;
            else if (c[0])    m_owner = 0;
            else if (c[1])    m_owner = 1;
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_q    = 0;
            end
        end else begin
            oth   = 1 - o;
            cti_o = (o == 0) ? m0_bus.cti : m1_bus.cti;
            leave = !c[o]
                 || (s_bus.ack && cti_o == 3'b111 && c[oth])
                 || (Q != 0 && s_bus.ack && m_q == int'(Q) - 1 && c[oth]);
            if (leave) m_owner = -1;
            else if (s_bus.ack && m_q < int'(Q)) m_q++;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset pulse issued mid-cycle (caller is at posedge+1).
    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    int acks;
    int gap;

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, CTI_INCR, 32'h0);
        drive(1, 1'b0, CTI_INCR, 32'h0);
        s_bus.ack    = 1'b0;
        s_bus.dat_sm = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        s_bus.ack = 1'b1;
        check("rst_gnt", gnt, 2'b00);
        check("rst_bus", sfields(), 76'h0);
        check("rst_ack", {m1_bus.ack, m0_bus.ack}, 2'b00);
        rst_n = 1'b1;
        s_bus.ack = 1'b0;

        // m0 alone: granted one cycle later, address forwarded, m1 never acked.
        drive(0, 1'b1, CTI_INCR, 32'hA000_0010);
        step();
        check("a_idle", obs_gnt, 2'b00);
        step();
        check("a_gnt", obs_gnt, 2'b01);
        check("a_adr", obs_sadr, 32'hA000_0010);
        s_bus.ack = 1'b1;
        s_bus.dat_sm = 32'h1234_5678;
        step();
        check("a_ack", obs_ack, 2'b01);
        drive(0, 1'b0, CTI_INCR, 32'h0);
        s_bus.ack = 1'b0;
        repeat (2) step();

        // Both request together after reset: m0 first, m1 after m0 drops cyc.
        pulse_reset();
        drive(0, 1'b1, CTI_INCR, 32'hA000_0100);
        drive(1, 1'b1, CTI_INCR, 32'hB000_0100);
        s_bus.ack = 1'b1;
        step();
        step();
        check("b_m0first", obs_gnt, 2'b01);
        acks = int'(obs_ack[0]);
        for (int i = 0; i < 10 && acks < 3; i++) begin
            step();
            if (obs_ack[0]) acks++;
        end
        check("b_acks", acks, 3);
        drive(0, 1'b0, CTI_INCR, 32'h0);
        s_bus.ack = 1'b0;
        gap = 0;
        for (int i = 0; i < 6 && obs_gnt != 2'b10; i++) begin
            step();
            if (obs_gnt == 2'b00) gap++;
        end
        check("b_m1", obs_gnt, 2'b10);
        check("b_gap", gap, 1);
        drive(1, 1'b0, CTI_INCR, 32'h0);
        repeat (2) step();

        // Quota: m0 holds cyc forever, m1 waits -> exactly Q m0 acks, gap, m1 served.
        pulse_reset();
        drive(0, 1'b1, CTI_INCR, 32'hA000_0200);
        step();
        step();
        drive(1, 1'b1, CTI_INCR, 32'hB000_0200);
        s_bus.ack = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (obs_ack[0]) acks++;
            if (obs_gnt != 2'b01) break;
        end
        check("c_quota", acks, Q);
        check("c_gap", obs_gnt, 2'b00);
        step();
        check("c_m1", obs_gnt, 2'b10);
        step();
        drive(1, 1'b0, CTI_INCR, 32'h0);
        s_bus.ack = 1'b0;
        step();
        step();
        step();
        check("c_m0back", obs_gnt, 2'b01);
        check("c_adr", obs_sadr, 32'hA000_0200);
        drive(0, 1'b0, CTI_INCR, 32'h0);
        repeat (2) step();

        // End-of-burst from m1 while m0 waits: release after that ack, m0 two cycles on.
        pulse_reset();
        drive(1, 1'b1, CTI_INCR, 32'hB000_0300);
        step();
        step();
        check("d_m1", obs_gnt, 2'b10);
        drive(0, 1'b1, CTI_INCR, 32'hA000_0300);
        repeat (2) step();
        m1_bus.cti = CTI_EOB;
        s_bus.ack  = 1'b1;
        step();
        check("d_rel", obs_ack, 2'b10);
        m1_bus.cti = CTI_INCR;
        s_bus.ack  = 1'b0;
        step();
        check("d_gap", obs_gnt, 2'b00);
        step();
        check("d_m0", obs_gnt, 2'b01);

        // Reset mid-grant: outputs clear at once; with both requesting m0 wins after.
        s_bus.ack = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("e_gnt", gnt, 2'b00);
        check("e_bus", sfields(), 76'h0);
        check("e_ack", {m1_bus.ack, m0_bus.ack}, 2'b00);
        #1;
        rst_n = 1'b1;
        s_bus.ack = 1'b0;
        step();
        step();
        check("e_m0", obs_gnt, 2'b01);

`ifdef WSHB_ARB_STATS_EN
        // m1 waits ten cycles behind m0: wait1 counts them, wait0 keeps its single IDLE cycle.
        pulse_reset();
        drive(0, 1'b1, CTI_INCR, 32'hA000_0400);
        drive(1, 1'b0, CTI_INCR, 32'h0);
        step();
        step();
        drive(1, 1'b1, CTI_INCR, 32'hB000_0400);
        repeat (10) step();
        check("f_w1", wait1, 16'd10);
        check("f_w0", wait0, 16'd1);
`endif

        // Random traffic against the model.
        drive(0, 1'b0, CTI_INCR, 32'h0);
        drive(1, 1'b0, CTI_INCR, 32'h0);
        for (int i = 0; i < 4000; i++) begin
            int r;
            if ($urandom_range(0, 15) == 0) m0_bus.cyc = ~m0_bus.cyc;
            if ($urandom_range(0, 9) == 0)  m1_bus.cyc = ~m1_bus.cyc;
            m0_bus.stb = 1'($urandom());  m1_bus.stb = 1'($urandom());
            m0_bus.we  = 1'($urandom());  m1_bus.we  = 1'($urandom());
            m0_bus.adr = $urandom();      m1_bus.adr = $urandom();
            m0_bus.sel = 4'($urandom());  m1_bus.sel = 4'($urandom());
            m0_bus.bte = 2'($urandom());  m1_bus.bte = 2'($urandom());
            m0_bus.dat_ms = $urandom();   m1_bus.dat_ms = $urandom();
            r = $urandom_range(0, 9);
            m0_bus.cti = (r == 0) ? CTI_EOB : (r == 1) ? CTI_CLASSIC : CTI_INCR;
            r = $urandom_range(0, 9);
            m1_bus.cti = (r == 0) ? CTI_EOB : (r == 1) ? CTI_CLASSIC : CTI_INCR;
            s_bus.ack    = 1'($urandom());
            s_bus.dat_sm = $urandom();
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check("r_rst", gnt, 2'b00);
                #1;
                rst_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
